instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  PC register and fetch sequencer feeding 32-bit instructions to the decoder/control stage.
//  Issues word requests to instruction memory and holds the returned instruction until control acknowledges it.
//  On acknowledge, takes the control stage's branch[5:0] and FLAGS and computes the next PC.
// PARAMETERS
//  PC_WIDTH   64   PC and address width in bits
//  RESET_PC   0    PC value loaded on reset (word aligned)
// PORTS
//  clk          in   1         clock; all state updates on rising edge
//  reset        in   1         synchronous, active-high reset
//  imem_req     out  1         fetch request; held high until imem_ready
//  imem_addr    out  PC_WIDTH  byte address of the requested word; stable while imem_req is high
//  imem_ready   in   1         imem_rdata valid this cycle; completes the request
//  imem_rdata   in   32        fetched instruction word
//  instruction  out  32        held instruction to decoder; 0 when instr_valid is low
//  instr_valid  out  1         instruction holds a valid word
//  instr_pc     out  PC_WIDTH  PC of the held instruction
//  instr_ack    in   1         control consumes instruction; branch inputs sampled this cycle
//  branch       in   6         [0]B [1]CBZ [2]CBNZ [3]B.cond [4]BR [5]reserved (ignored)
//  FLAGS        in   4         {N,Z,C,V} from ALU flag register
//  cond         in   4         B.cond condition code (instruction[3:0])
//  rt_zero      in   1         register read of Rt == 0, used by CBZ/CBNZ
//  BR_Address   in   26        B offset in words, signed
//  COND_BR_address in 19       CBZ/CBNZ/B.cond offset in words, signed
//  reg_target   in   PC_WIDTH  BR target (register value)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, imem_req=0, instr_valid=0, instruction=0, instr_pc=0, state=IDLE.
//  - Reset mid-request wins: request dropped, any later imem_ready in that cycle ignored.
//  - FSM IDLE -> FETCH (1 cycle after reset deasserts). FETCH: imem_req=1, imem_addr=pc.
//  - FETCH & imem_ready: latch imem_rdata->instruction, pc->instr_pc, instr_valid=1, imem_req=0 next cycle, -> HOLD.
//  - HOLD: instruction/instr_pc stable. instr_ack: evaluate next PC, instr_valid=0, -> FETCH next cycle.
//  - instr_ack while not in HOLD is ignored. imem_ready while not in FETCH is ignored.
//  - Minimum cadence: 1 instruction per 2 cycles with zero-wait memory (ready same cycle as req).
//  - Next PC (base = instr_pc), priority low bit first when multiple bits set:
//    B: base + sext(BR_Address)<<2 ; CBZ taken if rt_zero ; CBNZ taken if !rt_zero ;
//    B.cond taken per ARM codes 0-13 on FLAGS, 14/15 always taken ;
//    CBZ/CBNZ/B.cond target: base + sext(COND_BR_address)<<2 ; else base + 4.
//  - Arithmetic mod 2^PC_WIDTH; wrap-around at top of address space permitted, no flag.
//  - branch==0 or branch==6'b100000 -> base + 4.
// CONFIGURATION
//  BR_REG_EN defined: branch[4] (lowest priority after [0..3]) sets pc = {reg_target[PC_WIDTH-1:2],2'b00}.
//  BR_REG_EN undefined: branch[4] ignored, reg_target unused, treated as sequential (base + 4).
// TESTING
//  1 reset, RESET_PC=0, zero-wait imem, ack every HOLD -> imem_addr 0,4,8,12 on successive FETCHes.
//  2 imem_ready delayed 3 cycles -> imem_req/imem_addr held stable 4 cycles; instr_valid rises 1 cycle after ready.
//  3 instr_pc=0x100, branch=6'b000001, BR_Address=26'h3FFFFFE (-2) -> next imem_addr 0xF8.
//  4 instr_pc=0x40, branch=B.cond, cond=0(EQ): FLAGS=4'b0100 -> 0x40+off*4; FLAGS=4'b0000 -> 0x44.
//  5 CBZ with rt_zero=0 -> 0x44 ; CBNZ with rt_zero=0, COND_BR_address=5 -> 0x54.
//  6 reset asserted in FETCH with imem_ready high -> instr_valid stays 0; next fetch at RESET_PC;
//    with BR_REG_EN, branch=6'b010000, reg_target=0x2003 -> next imem_addr 0x2000.

Source files
------------

// File: rtl/instruction_fetch.sv
// PC register and fetch sequencer: requests one word, holds it for the decoder, then steps PC from branch/flag inputs.
// Latency: a zero-wait fetch gives instr_valid one cycle after the request; ack to the next request takes one cycle.
// Backpressure: the held word stays until instr_ack, and the request stays until imem_ready. Optional macro: BR_REG_EN.
module instruction_fetch #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instruction,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] instr_pc,
    input  logic                instr_ack,
    input  logic [5:0]          branch,
    input  logic [3:0]          FLAGS,
    input  logic [3:0]          cond,
    input  logic                rt_zero,
    input  logic [25:0]         BR_Address,
    input  logic [18:0]         COND_BR_address,
    input  logic [PC_WIDTH-1:0] reg_target
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] b_off;
    logic [PC_WIDTH-1:0] c_off;
    logic                cond_true;
    logic                n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = FLAGS;
    assign b_off = {{(PC_WIDTH-28){BR_Address[25]}}, BR_Address, 2'b00};
    assign c_off = {{(PC_WIDTH-21){COND_BR_address[18]}}, COND_BR_address, 2'b00};

`ifdef BR_REG_EN
    logic unused_bits;
    assign unused_bits = ^{branch[5], reg_target[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{branch[5:4], reg_target};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) state_nxt = HOLD;
            end
            HOLD:  if (instr_ack) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_addr = pc;

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:    cond_true = z_f;
            4'd1:    cond_true = !z_f;
            4'd2:    cond_true = c_f;
            4'd3:    cond_true = !c_f;
            4'd4:    cond_true = n_f;
            4'd5:    cond_true = !n_f;
            4'd6:    cond_true = v_f;
            4'd7:    cond_true = !v_f;
            4'd8:    cond_true = c_f && !z_f;
            4'd9:    cond_true = !c_f || z_f;
            4'd10:   cond_true = (n_f == v_f);
            4'd11:   cond_true = (n_f != v_f);
            4'd12:   cond_true = !z_f && (n_f == v_f);
            4'd13:   cond_true = z_f || (n_f != v_f);
            default: cond_true = 1'b1;
        endcase
    end

    // Lowest set branch bit selects the kind; an untaken conditional falls through rather than trying higher bits.
    always_comb begin
        next_pc = instr_pc + PC_WIDTH'(4);
        if (branch[0]) begin
            next_pc = instr_pc + b_off;
        end else if (branch[1]) begin
            if (rt_zero) next_pc = instr_pc + c_off;
        end else if (branch[2]) begin
            if (!rt_zero) next_pc = instr_pc + c_off;
        end else if (branch[3]) begin
            if (cond_true) next_pc = instr_pc + c_off;
        end
`ifdef BR_REG_EN
        else if (branch[4]) begin
            next_pc = {reg_target[PC_WIDTH-1:2], 2'b00};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            instruction <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (state == FETCH && imem_ready) begin
            instruction <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
        end else if (state == HOLD && instr_ack) begin
            pc          <= next_pc;
            instruction <= '0;
            instr_valid <= 1'b0;
        end
    end

endmodule
